// File: rtl/progress_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// progress_sequencer_pkg
// Display constants shared between the progress sequencer and the OLED
// pixel stage, plus the sequencer state encoding.
//   PROG_MAX_DEFAULT : full-bar progress value; the pixel stage also uses it
//                      to scale the bar length
//   OLED_W / OLED_H  : panel geometry in pixels
//   state_t          : 2-bit sequencer state (IDLE=0, RUN=1, PAUSE=2, DONE=3)
// ---------------------------------------------------------------------------
package progress_sequencer_pkg;

    localparam int PROG_MAX_DEFAULT = 72;
    localparam int OLED_W           = 96;
    localparam int OLED_H           = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // RUN and PAUSE are the two states in which a run is in progress.
    function automatic logic is_active(input state_t s);
        return (s == ST_RUN) || (s == ST_PAUSE);
    endfunction

endpackage

// File: rtl/progress_sequencer_tick_prescaler.sv
// ---------------------------------------------------------------------------
// progress_sequencer_tick_prescaler
// Free-running divider that produces one terminal-count pulse every
// TICKS_PER_STEP enabled cycles.
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   enable   : count this cycle
//   clear    : synchronous clear to 0 (wins over enable)
//   terminal : combinational, high when enabled and the count is at
//              TICKS_PER_STEP-1, i.e. the count wraps on this edge
// ---------------------------------------------------------------------------
module progress_sequencer_tick_prescaler
    import progress_sequencer_pkg::*;
#(
    parameter int PRESC_W        = 24,
    parameter int TICKS_PER_STEP = 625000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic clear,
    output logic terminal
);

    localparam logic [PRESC_W-1:0] LAST = PRESC_W'(TICKS_PER_STEP - 1);

    logic [PRESC_W-1:0] count;

    // The compare is an equality on the last value, so the count must never
    // be loaded with anything above LAST; the only loads are 0 and +1.
    assign terminal = enable && (count == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/progress_sequencer.sv
// ---------------------------------------------------------------------------
// progress_sequencer
// Steps an internal progress count from 0 to PROG_MAX at a fixed tick rate
// under start/pause/abort control, and hands the value to the OLED pixel
// stage only at frame boundaries so a frame never shows two bar lengths.
//   clk         : 6.25 MHz OLED clock
//   reset_n     : asynchronous active-low reset
//   start       : pulse, begin or restart a run from 0
//   pause       : level, freeze prescaler and progress while high
//   abort       : pulse, cancel the run and return to idle with progress 0
//   frame_begin : pulse at pixel index 0 from the OLED driver
//   progress    : frame-synchronised progress for the pixel stage
//   running     : high while in RUN or PAUSE
//   done        : one-cycle pulse when the run reaches PROG_MAX
// ---------------------------------------------------------------------------
module progress_sequencer
    import progress_sequencer_pkg::*;
#(
    parameter int TICKS_PER_STEP = 625000,
    parameter int PROG_MAX       = PROG_MAX_DEFAULT,
    parameter int PRESC_W        = 24
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       pause,
    input  logic       abort,
    input  logic       frame_begin,
    output logic [7:0] progress,
    output logic       running,
    output logic       done
);

    localparam logic [7:0] PROG_TOP  = 8'(PROG_MAX);
    localparam logic [7:0] PROG_LAST = 8'(PROG_MAX - 1);

    state_t     state;
    logic [7:0] progress_int;
    logic       advance;
    logic       tick;

    // The prescaler only moves on cycles that end up in RUN. A PAUSE cycle
    // with pause released counts too, so resuming neither loses nor gains a
    // cycle. abort and start outrank everything and clear it instead.
    assign advance = is_active(state) && !pause && !abort && !start;

    progress_sequencer_tick_prescaler #(
        .PRESC_W        (PRESC_W),
        .TICKS_PER_STEP (TICKS_PER_STEP)
    ) u_prescaler (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (advance),
        .clear    (abort || start),
        .terminal (tick)
    );

    // Sequencer FSM, progress counter and frame latch. Priority on a shared
    // edge is abort > start > pause > tick. abort/start clear the displayed
    // value at once rather than waiting for a frame; a one-frame tear is
    // accepted there. Otherwise frame_begin samples the pre-edge
    // progress_int, so an increment on the same edge shows one frame later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            progress_int <= 8'd0;
            progress     <= 8'd0;
            running      <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state        <= ST_IDLE;
                progress_int <= 8'd0;
                progress     <= 8'd0;
                running      <= 1'b0;
            end else if (start) begin
                state        <= ST_RUN;
                progress_int <= 8'd0;
                progress     <= 8'd0;
                running      <= 1'b1;
            end else begin
                if (frame_begin) begin
                    progress <= progress_int;
                end
                case (state)
                    ST_RUN, ST_PAUSE: begin
                        if (pause) begin
                            state   <= ST_PAUSE;
                            running <= 1'b1;
                        end else begin
                            state   <= ST_RUN;
                            running <= 1'b1;
                            if (tick) begin
                                if (progress_int < PROG_TOP) begin
                                    progress_int <= progress_int + 8'd1;
                                end
                                if (progress_int == PROG_LAST) begin
                                    state   <= ST_DONE;
                                    running <= 1'b0;
                                    done    <= 1'b1;
                                end
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_progress_sequencer.sv
// ---------------------------------------------------------------------------
// tb_progress_sequencer
// Self-checking bench for progress_sequencer with TICKS_PER_STEP=4 and
// PROG_MAX=5. A behavioural reference model predicts progress/running/done
// for every clock edge; predictions are queued when stimulus is applied and
// popped and compared on the following falling edge. Each scenario task adds
// its own targeted checks for timing of done, pause resume and clears.
// ---------------------------------------------------------------------------
module tb_progress_sequencer;

    localparam int TPS   = 4;
    localparam int PMAX  = 5;
    localparam int PW    = 4;
    localparam int FRAME = 8;

    typedef struct packed {
        logic [7:0] progress;
        logic       running;
        logic       done;
    } exp_t;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       pause;
    logic       abort;
    logic       frame_begin;
    logic [7:0] progress;
    logic       running;
    logic       done;

    int   total;
    int   bad;
    int   cyc;
    bit   frame_auto;
    exp_t exp_q[$];

    // reference model state (0 idle, 1 run, 2 pause, 3 done)
    int m_state;
    int m_presc;
    int m_pint;
    int m_prog;
    bit m_run;
    bit m_done;

    progress_sequencer #(
        .TICKS_PER_STEP (TPS),
        .PROG_MAX       (PMAX),
        .PRESC_W        (PW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .pause       (pause),
        .abort       (abort),
        .frame_begin (frame_begin),
        .progress    (progress),
        .running     (running),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute time limit so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic model_reset();
        m_state = 0;
        m_presc = 0;
        m_pint  = 0;
        m_prog  = 0;
        m_run   = 0;
        m_done  = 0;
    endtask

    // Advance the reference model by one clock edge using the current inputs.
    task automatic model_step();
        int old_pint;
        old_pint = m_pint;
        m_done   = 0;
        if (abort) begin
            m_state = 0; m_pint = 0; m_presc = 0; m_prog = 0;
        end else if (start) begin
            m_state = 1; m_pint = 0; m_presc = 0; m_prog = 0;
        end else begin
            if (m_state == 1 || m_state == 2) begin
                if (pause) begin
                    m_state = 2;
                end else begin
                    m_state = 1;
                    m_presc = m_presc + 1;
                    if (m_presc == TPS) begin
                        m_presc = 0;
                        m_pint  = m_pint + 1;
                        if (m_pint == PMAX) begin
                            m_state = 3;
                            m_done  = 1;
                        end
                    end
                end
            end
            if (frame_begin) m_prog = old_pint;
        end
        m_run = (m_state == 1 || m_state == 2);
    endtask

    // Apply the current inputs for one edge, queue the prediction, and
    // return 1 time unit after the edge with pulses released.
    task automatic tick_cycle();
        exp_t e;
        if (frame_auto) frame_begin = ((cyc % FRAME) == 0);
        model_step();
        e.progress = 8'(m_prog);
        e.running  = m_run;
        e.done     = m_done;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        cyc   = cyc + 1;
        start = 1'b0;
        abort = 1'b0;
        if (!frame_auto) frame_begin = 1'b0;
    endtask

    // Scoreboard: compare each queued prediction on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total = total + 1;
            if (progress !== e.progress) begin
                bad = bad + 1;
                $display("[TB] FAIL sb_progress cyc=%0d: got %0d expected %0d", cyc, progress, e.progress);
            end
            total = total + 1;
            if (running !== e.running) begin
                bad = bad + 1;
                $display("[TB] FAIL sb_running cyc=%0d: got %0b expected %0b", cyc, running, e.running);
            end
            total = total + 1;
            if (done !== e.done) begin
                bad = bad + 1;
                $display("[TB] FAIL sb_done cyc=%0d: got %0b expected %0b", cyc, done, e.done);
            end
        end
    end

    task automatic test_reset();
        reset_n = 1'b0; start = 0; pause = 0; abort = 0; frame_begin = 0;
        model_reset();
        #2;
        total = total + 1;
        if ({progress, running, done} !== 10'd0) begin
            bad = bad + 1;
            $display("[TB] FAIL reset_state: got %0h expected 0", {progress, running, done});
        end
        #10;
        reset_n = 1'b1;
        // idle must ignore pause and frame activity
        pause = 1'b1;
        repeat (9) tick_cycle();
        pause = 1'b0;
        total = total + 1;
        if (running !== 1'b0) begin
            bad = bad + 1;
            $display("[TB] FAIL idle_running: got %0b expected 0", running);
        end
    endtask

    task automatic test_run();
        int done_cnt;
        int done_at;
        done_cnt = 0;
        done_at  = -1;
        start = 1'b1;
        tick_cycle();
        total = total + 1;
        if (running !== 1'b1) begin
            bad = bad + 1;
            $display("[TB] FAIL run_running: got %0b expected 1", running);
        end
        for (int i = 1; i <= 30; i++) begin
            tick_cycle();
            if (done === 1'b1) begin
                done_cnt = done_cnt + 1;
                done_at  = i;
                total = total + 1;
                if (running !== 1'b0) begin
                    bad = bad + 1;
                    $display("[TB] FAIL run_running_at_done: got %0b expected 0", running);
                end
            end
        end
        total = total + 1;
        if (done_cnt !== 1 || done_at !== 20) begin
            bad = bad + 1;
            $display("[TB] FAIL run_done_timing: got count=%0d at=%0d expected count=1 at=20", done_cnt, done_at);
        end
        total = total + 1;
        if (progress !== 8'(PMAX)) begin
            bad = bad + 1;
            $display("[TB] FAIL run_final_progress: got %0d expected %0d", progress, PMAX);
        end
    endtask

    task automatic test_restart_from_done();
        int done_at;
        done_at = -1;
        start = 1'b1;
        tick_cycle();
        total = total + 1;
        if (progress !== 8'd0 || running !== 1'b1) begin
            bad = bad + 1;
            $display("[TB] FAIL restart_clear: got progress=%0d running=%0b expected 0 1", progress, running);
        end
        for (int i = 1; i <= 24; i++) begin
            tick_cycle();
            if (done === 1'b1 && done_at < 0) done_at = i;
        end
        total = total + 1;
        if (done_at !== 20) begin
            bad = bad + 1;
            $display("[TB] FAIL restart_done_at: got %0d expected 20", done_at);
        end
    endtask

    task automatic test_pause();
        int done_at;
        done_at = -1;
        start = 1'b1;
        tick_cycle();
        for (int i = 1; i <= 8; i++) tick_cycle();
        pause = 1'b1;
        for (int i = 9; i <= 15; i++) begin
            tick_cycle();
            total = total + 1;
            if (running !== 1'b1 || done !== 1'b0) begin
                bad = bad + 1;
                $display("[TB] FAIL pause_hold: got running=%0b done=%0b expected 1 0", running, done);
            end
        end
        pause = 1'b0;
        for (int i = 16; i <= 32; i++) begin
            tick_cycle();
            if (done === 1'b1 && done_at < 0) done_at = i;
        end
        total = total + 1;
        if (done_at !== 27) begin
            bad = bad + 1;
            $display("[TB] FAIL pause_run_length: got %0d expected 27", done_at);
        end
        // let a frame latch the final value before the restart test
        repeat (10) tick_cycle();
        total = total + 1;
        if (progress !== 8'(PMAX)) begin
            bad = bad + 1;
            $display("[TB] FAIL pause_final_progress: got %0d expected %0d", progress, PMAX);
        end
    endtask

    task automatic test_abort_on_tick();
        int done_seen;
        done_seen = 0;
        start = 1'b1;
        tick_cycle();
        for (int i = 1; i <= 15; i++) tick_cycle();
        abort = 1'b1;
        tick_cycle();
        total = total + 1;
        if (progress !== 8'd0 || running !== 1'b0 || done !== 1'b0) begin
            bad = bad + 1;
            $display("[TB] FAIL abort_clear: got progress=%0d running=%0b done=%0b expected 0 0 0", progress, running, done);
        end
        for (int i = 0; i < 25; i++) begin
            tick_cycle();
            if (done === 1'b1 || progress !== 8'd0) done_seen = done_seen + 1;
        end
        total = total + 1;
        if (done_seen !== 0) begin
            bad = bad + 1;
            $display("[TB] FAIL abort_idle: got %0d active cycles expected 0", done_seen);
        end
    endtask

    task automatic test_frame_coincide();
        frame_auto = 1'b0;
        start = 1'b1;
        tick_cycle();
        for (int i = 1; i <= 7; i++) tick_cycle();
        frame_begin = 1'b1;
        tick_cycle();
        total = total + 1;
        if (progress !== 8'd1) begin
            bad = bad + 1;
            $display("[TB] FAIL frame_coincide_old: got %0d expected 1", progress);
        end
        tick_cycle();
        total = total + 1;
        if (progress !== 8'd1) begin
            bad = bad + 1;
            $display("[TB] FAIL frame_hold: got %0d expected 1", progress);
        end
        frame_begin = 1'b1;
        tick_cycle();
        total = total + 1;
        if (progress !== 8'd2) begin
            bad = bad + 1;
            $display("[TB] FAIL frame_next: got %0d expected 2", progress);
        end
        abort = 1'b1;
        tick_cycle();
        frame_auto = 1'b1;
    endtask

    task automatic test_async_reset();
        int done_at;
        done_at = -1;
        start = 1'b1;
        tick_cycle();
        for (int i = 1; i <= 17; i++) tick_cycle();
        @(negedge clk);
        #1;
        total = total + 1;
        if (running !== 1'b1 || progress === 8'd0) begin
            bad = bad + 1;
            $display("[TB] FAIL pre_reset_active: got progress=%0d running=%0b expected nonzero 1", progress, running);
        end
        reset_n = 1'b0;
        #1;
        total = total + 1;
        if ({progress, running, done} !== 10'd0) begin
            bad = bad + 1;
            $display("[TB] FAIL async_reset: got %0h expected 0", {progress, running, done});
        end
        model_reset();
        #10;
        reset_n = 1'b1;
        start = 1'b1;
        tick_cycle();
        for (int i = 1; i <= 22; i++) begin
            tick_cycle();
            if (done === 1'b1 && done_at < 0) done_at = i;
        end
        total = total + 1;
        if (done_at !== 20) begin
            bad = bad + 1;
            $display("[TB] FAIL post_reset_done_at: got %0d expected 20", done_at);
        end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        cyc        = 0;
        frame_auto = 1'b1;
        test_reset();
        test_run();
        test_restart_from_done();
        test_pause();
        test_restart_from_done();
        test_abort_on_tick();
        test_frame_coincide();
        test_async_reset();
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
